// File: rtl/fetch_q.sv
// Instruction fetch stage: issues sequential fetches with bounded outstanding
// requests, queues returned words with their PCs and presents them to decode.
module fetch_q #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0010,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            clr,
  output logic            mio_req,
  output logic [XLEN-1:0] mio_addr,
  input  logic            mio_ack,
  input  logic            mio_vld,
  input  logic [XLEN-1:0] mio_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            pen,
  input  logic            pen_rdy,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] instr,
  output logic            err
);

  localparam int unsigned     PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CW      = $clog2(DEPTH + 1);
  localparam int unsigned     SW      = CW + 1;
  localparam logic [SW-1:0]   DEPTH_S = SW'(DEPTH);
  localparam logic [SW-1:0]   MAXO_S  = SW'(MAX_OUT);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   live_q, live_d;
  logic [CW-1:0]   stale_q, stale_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            err_q, err_d;
  entry_t          head_q, head_d;
  entry_t          mem_q [DEPTH];

  logic [SW-1:0] inflight;
  logic [SW-1:0] occupied;
  logic          issue;
  logic          accept;
  logic          spurious;
  logic          stale_hit;
  logic          live_hit;
  logic          push;
  logic          pop;
  entry_t        push_entry;

  // Credit check: every live fetch is guaranteed a free queue slot on return.
  assign inflight   = {1'b0, live_q} + {1'b0, stale_q};
  assign occupied   = {1'b0, count_q} + {1'b0, live_q};
  assign issue      = !clr && !redirect && (inflight < MAXO_S) && (occupied < DEPTH_S);
  assign accept     = issue && mio_ack;

  assign spurious   = mio_vld && (inflight == '0);
  assign stale_hit  = mio_vld && (stale_q != '0);
  assign live_hit   = mio_vld && (stale_q == '0) && (live_q != '0);
  assign push       = live_hit && !redirect;
  assign pop        = (count_q != '0) && pen_rdy && !redirect;
  assign push_entry = '{pc: resp_pc_q, word: mio_rdata};

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    live_d     = live_q;
    stale_d    = stale_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    err_d      = err_q | spurious;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      // Fetches still in flight become stale; a response arriving now retires one of them.
      stale_d    = stale_q - CW'(stale_hit) + live_q - CW'(live_hit);
      live_d     = '0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (push)   resp_pc_d  = resp_pc_q + PC_STEP;
      live_d   = live_q + CW'(accept) - CW'(live_hit);
      stale_d  = stale_q - CW'(stale_hit);
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
    end
  end

  // Head register tracks the entry at the next read pointer; it holds when the queue drains.
  always_comb begin
    head_d = head_q;
    if (!redirect && (count_d != '0)) begin
      if (push && (rd_ptr_d == wr_ptr_q)) head_d = push_entry;
      else                                head_d = mem_q[rd_ptr_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (clr) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      live_q     <= '0;
      stale_q    <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      err_q      <= 1'b0;
      head_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      live_q     <= live_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      err_q      <= err_d;
      head_q     <= head_d;
    end
  end

  // NOTE: the queue storage has no reset; count_q alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign mio_req  = issue;
  assign mio_addr = fetch_pc_q;
  assign pen      = (count_q != '0);
  assign pc       = head_q.pc;
  assign instr    = head_q.word;
  assign next_pc  = head_q.pc + PC_STEP;
  assign err      = err_q;

endmodule
